// File: rtl/security_lane_arbiter.sv
// Lane scheduler: one scanner shared by regular/staff/VIP queues; grant registered one cycle after request, period SCAN_CYCLES+2.
// Define LANE_PARITY_CHECK_EN to treat odd parity of the latched bag byte as a scanner alarm; requests simply wait while busy.
module security_lane_arbiter #(
   parameter int SCAN_CYCLES  = 8,
   parameter int STARVE_LIMIT = 3,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       req,
   input  logic [7:0]       baggage_data,
   input  logic             scan_alarm,
   input  logic             clear,
   output logic [2:0]       grant,
   output logic             scanner_en,
   output logic [7:0]       scanner_data,
   output logic             busy,
   output logic [1:0]       state,
   output logic [3:0]       light,
   output logic [CNT_W-1:0] served_count,
   output logic [3:0]       alarm_count
);

   localparam logic [1:0] IDLE    = 2'b00;
   localparam logic [1:0] SCAN    = 2'b01;
   localparam logic [1:0] HOLD    = 2'b10;
   localparam logic [1:0] RELEASE = 2'b11;

   logic [1:0] state_r;
   logic [1:0] next_state;
   logic [7:0] timer;
   logic [3:0] starve;
   logic [2:0] winner;
   logic       alarm_hit;
   logic       scan_done;
   logic       en_next;
   logic       busy_next;
   logic [3:0] light_next;

   assign state     = state_r;
   assign scan_done = (state_r == SCAN) && (timer == 8'd0);

`ifdef LANE_PARITY_CHECK_EN
   assign alarm_hit = scan_alarm | (^scanner_data);
`else
   assign alarm_hit = scan_alarm;
`endif

   // Starved regular queue overrides the fixed VIP > staff > regular order.
   always_comb begin
      winner = 3'b000;
      if (req[0] && (starve >= 4'(STARVE_LIMIT)))
         winner = 3'b001;
      else if (req[2])
         winner = 3'b100;
      else if (req[1])
         winner = 3'b010;
      else if (req[0])
         winner = 3'b001;
   end

   always_comb begin
      next_state = state_r;
      case (state_r)
         IDLE:    if (req != 3'b000) next_state = SCAN;
         SCAN:    if (scan_done) next_state = alarm_hit ? HOLD : RELEASE;
         HOLD:    if (clear) next_state = RELEASE;
         RELEASE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Status outputs are decoded from next_state so they are registered alongside the state.
   always_comb begin
      en_next    = (next_state == SCAN);
      busy_next  = (next_state != IDLE);
      light_next = 4'b0001 << next_state;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= IDLE;
         scanner_en <= 1'b0;
         busy       <= 1'b0;
         light      <= 4'b0001;
      end else begin
         state_r    <= next_state;
         scanner_en <= en_next;
         busy       <= busy_next;
         light      <= light_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         grant        <= 3'b000;
         scanner_data <= 8'h00;
         timer        <= 8'd0;
         starve       <= 4'd0;
         served_count <= '0;
         alarm_count  <= 4'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req != 3'b000) begin
                  grant        <= winner;
                  scanner_data <= baggage_data;
                  timer        <= 8'(SCAN_CYCLES - 1);
                  if (winner == 3'b001)
                     starve <= 4'd0;
                  else if (req[0] && (starve != 4'd15))
                     starve <= starve + 4'd1;
               end
            end
            SCAN: begin
               if (timer != 8'd0)
                  timer <= timer - 8'd1;
               else if (alarm_hit && (alarm_count != 4'd15))
                  alarm_count <= alarm_count + 4'd1;
            end
            RELEASE: begin
               served_count <= served_count + CNT_W'(1);
               grant        <= 3'b000;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_security_lane_arbiter.sv
// Randomized and directed bench for security_lane_arbiter checked against a passenger-level reference model.
module tb_security_lane_arbiter;
   localparam int SC = 8;
   localparam int SL = 3;
   localparam int CW = 8;

   logic          clk;
   logic          reset;
   logic [2:0]    req;
   logic [7:0]    baggage_data;
   logic          scan_alarm;
   logic          clear;
   logic [2:0]    grant;
   logic          scanner_en;
   logic [7:0]    scanner_data;
   logic          busy;
   logic [1:0]    state;
   logic [3:0]    light;
   logic [CW-1:0] served_count;
   logic [3:0]    alarm_count;

   security_lane_arbiter #(.SCAN_CYCLES(SC), .STARVE_LIMIT(SL), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .req(req), .baggage_data(baggage_data),
      .scan_alarm(scan_alarm), .clear(clear), .grant(grant), .scanner_en(scanner_en),
      .scanner_data(scanner_data), .busy(busy), .state(state), .light(light),
      .served_count(served_count), .alarm_count(alarm_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int m_starve = 0;
   int m_served = 0;
   int m_alarms = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Winner from the queue rules: a starved regular goes first, else VIP > staff > regular.
   function automatic logic [2:0] pick(input logic [2:0] r, input int s);
      if (r[0] && s >= SL) return 3'b001;
      if (r[2]) return 3'b100;
      if (r[1]) return 3'b010;
      if (r[0]) return 3'b001;
      return 3'b000;
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, 32'(state), 32'd0);
      check({tag, "_grant"}, 32'(grant), 32'd0);
      check({tag, "_light"}, 32'(light), 32'b0001);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_en"}, 32'(scanner_en), 32'd0);
      check({tag, "_data"}, 32'(scanner_data), 32'd0);
      check({tag, "_served"}, 32'(served_count), 32'd0);
      check({tag, "_alarms"}, 32'(alarm_count), 32'd0);
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      reset = 1'b0;
      req = 3'b000; clear = 1'b0; scan_alarm = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_values(tag);
      reset = 1'b1;
      m_starve = 0; m_served = 0; m_alarms = 0;
   endtask

   // Called at a falling edge with the DUT in IDLE; returns at a falling edge back in IDLE.
   task automatic passenger(input logic [2:0] r, input logic [7:0] d, input bit a,
                            input int hold, output logic [2:0] g);
      logic [2:0] eg;
      bit         alarm;
      eg = pick(r, m_starve);
`ifdef LANE_PARITY_CHECK_EN
      alarm = a | (^d);
`else
      alarm = a;
`endif
      req = r; baggage_data = d;
      scan_alarm = 1'($urandom); clear = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (eg == 3'b001) m_starve = 0;
      else if (r[0] && m_starve < 15) m_starve++;
      check("grant", 32'(grant), 32'(eg));
      check("scan_data", 32'(scanner_data), 32'(d));
      check("scan_light", 32'(light), 32'b0010);
      check("scan_busy", 32'(busy), 32'd1);
      req = 3'($urandom);
      baggage_data = 8'($urandom);
      for (int k = 1; k <= SC; k++) begin
         check("scan_state", 32'(state), 32'd1);
         check("scan_en", 32'(scanner_en), 32'd1);
         scan_alarm = (k == SC) ? a : 1'($urandom);
         clear = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      scan_alarm = 1'($urandom);
      if (alarm) begin
         if (m_alarms < 15) m_alarms++;
         check("hold_state", 32'(state), 32'd2);
         check("hold_light", 32'(light), 32'b0100);
         check("hold_alarms", 32'(alarm_count), 32'(m_alarms));
         for (int h = 0; h < hold; h++) begin
            clear = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("hold_keep", 32'({state, scanner_en, grant}), 32'({2'd2, 1'b0, eg}));
         end
         clear = 1'b1;
         @(posedge clk);
         @(negedge clk);
         clear = 1'b0;
      end
      check("rel_state", 32'(state), 32'd3);
      check("rel_light", 32'(light), 32'b1000);
      check("rel_grant", 32'(grant), 32'(eg));
      check("rel_en", 32'(scanner_en), 32'd0);
      check("rel_served", 32'(served_count), 32'(m_served));
      check("rel_alarms", 32'(alarm_count), 32'(m_alarms));
      clear = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      m_served = (m_served + 1) % (1 << CW);
      check("idle_state", 32'(state), 32'd0);
      check("idle_grant", 32'(grant), 32'd0);
      check("idle_light", 32'(light), 32'b0001);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_served", 32'(served_count), 32'(m_served));
      check("idle_data_hold", 32'(scanner_data), 32'(d));
      req = 3'b000; clear = 1'b0; scan_alarm = 1'b0;
      g = eg;
   endtask

   initial begin
      logic [2:0] g;
      logic [2:0] order [5];
      logic [7:0] d;
      order[0] = 3'b100; order[1] = 3'b100; order[2] = 3'b100;
      order[3] = 3'b001; order[4] = 3'b100;
      reset = 1'b0; req = 3'b000; baggage_data = 8'h00; scan_alarm = 1'b0; clear = 1'b0;
      apply_reset("por");

      // Priority plus starvation relief with all three queues waiting.
      passenger(3'b111, 8'hA5, 1'b0, 0, g);
      check("prio_grant", 32'(g), 32'(order[0]));
      check("prio_served", 32'(served_count), 32'd1);
      for (int i = 1; i < 5; i++) begin
         passenger(3'b111, 8'h00, 1'b0, 0, g);
         check("starve_order", 32'(g), 32'(order[i]));
      end

      // Idle with no request stays idle.
      @(posedge clk);
      @(negedge clk);
      check("idle_no_req", 32'(state), 32'd0);

      // Alarm in the last scan cycle, held 20 cycles until clear.
      passenger(3'b001, 8'h03, 1'b1, 20, g);
      check("alarm_count1", 32'(alarm_count), 32'd1);

      // Reset in the middle of a scan aborts the passenger.
      req = 3'b010; baggage_data = 8'h5C;
      @(posedge clk);
      for (int i = 0; i < 3; i++) @(negedge clk);
      check("midscan_state", 32'(state), 32'd1);
      apply_reset("midscan");

      // Parity: 8'h01 is odd, 8'h03 is even.
      passenger(3'b001, 8'h01, 1'b0, 2, g);
      passenger(3'b010, 8'h03, 1'b0, 0, g);

      // Random traffic long enough to wrap served_count and saturate alarm_count.
      for (int n = 0; n < 290; n++) begin
         d = 8'($urandom);
         passenger(3'($urandom_range(1, 7)), d, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), g);
      end
      check("alarm_sat", 32'(alarm_count), 32'(m_alarms));
      check("served_final", 32'(served_count), 32'(m_served));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
